seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg2hex.sv | 35 +++
 rtl/seg_scan_decoder.sv | 99 +++++++++
 tb/tb_seg_scan_decoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the scanned 7-segment decoder: segment codes for hex 0..F,
// digit count and the capture FSM state type.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-high segment codes, bit order {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h73;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg2hex.sv
// Combinational 7-segment pattern to hex nibble decoder; legal is low for any
// pattern that is not one of the sixteen hex glyphs.
module seg2hex
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       legal
);

  always_comb begin
    hex   = 4'h0;
    legal = 1'b1;
    case (seg)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a 4-digit hex value from a multiplexed 7-segment display bus by capturing
// each digit once it has been stable for SETTLE_CYCLES, and emitting complete frames.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        frame_err,
  output scan_state_e dbg_state
);

  // cnt_q reaches this value on the last cycle before the capture edge.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 2);

  logic [10:0]           in_q, in_d;
  logic [7:0]            cnt_q, cnt_d;
  scan_state_e           state_q, state_d;
  logic [15:0]           digit_q, digit_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic                  err_q, err_d;
  logic [15:0]           value_q, value_d;
  logic                  fv_q, fv_d;
  logic                  fe_q, fe_d;

  logic [3:0] hex;
  logic       legal;
  logic       changed, one_hot, capture, emit;

  seg2hex u_seg2hex (
    .seg   (seg),
    .hex   (hex),
    .legal (legal)
  );

  always_comb begin
    in_d    = {an, seg};
    changed = (in_d != in_q);
    one_hot = $onehot(an);
    cnt_d   = changed ? 8'd0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);

    capture = !changed && one_hot && (state_q == ST_SETTLE) && (cnt_q == SETTLE_LAST);

    state_d = state_q;
    if (changed) begin
      state_d = one_hot ? ST_SETTLE : ST_WAIT;
    end else if (capture) begin
      state_d = ST_HELD;
    end

    digit_d = digit_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && an[i] && legal) digit_d[4*i +: 4] = hex;
    end

    // A capture on the emission cycle starts the next frame with only its own contribution.
    emit    = (seen_q == {NUM_DIGITS{1'b1}});
    seen_d  = (emit ? '0 : seen_q) | (capture ? an : '0);
    err_d   = (emit ? 1'b0 : err_q) | (capture && !legal);
    value_d = emit ? digit_q : value_q;
    fv_d    = emit;
    fe_d    = emit && err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q    <= '0;
      cnt_q   <= '0;
      state_q <= ST_WAIT;
      digit_q <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
      value_q <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      in_q    <= in_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      digit_q <= digit_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      value_q <= value_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end

  assign value       = value_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans digit sequences and checks frames,
// error flags, latency and reset behaviour against hand-computed values.
module tb_seg_scan_decoder;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic        frame_valid;
  logic        frame_err;
  scan_state_e dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          pulse_cnt = 0;
  int          last_cyc = 0;
  logic [15:0] last_value = '0;
  logic        last_err = 1'b0;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .value       (value),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .dbg_state   (dbg_state)
  );

  // Frame monitor: counts posedges and records every frame_valid pulse.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (frame_valid === 1'b1) begin
      pulse_cnt  = pulse_cnt + 1;
      last_cyc   = cyc;
      last_value = value;
      last_err   = frame_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives the pair and returns at the negedge n cycles later.
  task automatic present(input logic [3:0] a, input logic [6:0] s, input int n);
    an        = a;
    seg       = s;
    start_cyc = cyc;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    an    = 4'h0;
    seg   = 7'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_value", value, 16'h0000);
    check_eq("rst_fv", frame_valid, 1'b0);
    check_eq("rst_fe", frame_err, 1'b0);
    check_eq("rst_state", dbg_state, ST_WAIT);
    rst_n = 1'b1;
    present(4'h0, 7'h00, 2);

    // Basic scan 1,2,3,4 -> 0x4321, frame one cycle after the last capture edge
    pulse_cnt = 0;
    present(4'b0001, 7'h30, 6);
    present(4'b0010, 7'h6D, 6);
    present(4'b0100, 7'h79, 6);
    present(4'b1000, 7'h33, 6);
    check_eq("basic_pulses", pulse_cnt, 1);
    check_eq("basic_value", last_value, 16'h4321);
    check_eq("basic_err", last_err, 1'b0);
    check_eq("basic_latency", last_cyc, start_cyc + 5);
    check_eq("basic_held", dbg_state, ST_HELD);
    present(4'h0, 7'h00, 3);

    // Each pair held one cycle short of the settle time: nothing captured
    pulse_cnt = 0;
    present(4'b0001, 7'h7E, 3);
    present(4'b0010, 7'h7E, 3);
    present(4'b0100, 7'h7E, 3);
    present(4'b1000, 7'h7E, 3);
    present(4'h0, 7'h00, 4);
    check_eq("short_pulses", pulse_cnt, 0);
    check_eq("short_value", value, 16'h4321);

    // Illegal pattern on digit 2: error frame, digit 2 keeps its prior nibble
    pulse_cnt = 0;
    present(4'b0001, 7'h77, 6);
    present(4'b0010, 7'h1F, 6);
    present(4'b0100, 7'h00, 6);
    present(4'b1000, 7'h4E, 6);
    check_eq("illegal_pulses", pulse_cnt, 1);
    check_eq("illegal_value", last_value, 16'hC3BA);
    check_eq("illegal_err", last_err, 1'b1);
    present(4'h0, 7'h00, 3);

    // Multi-hot an between digits is blanking
    pulse_cnt = 0;
    present(4'b0001, 7'h7E, 6);
    present(4'b0011, 7'h5B, 10);
    check_eq("blank_state", dbg_state, ST_WAIT);
    present(4'b0010, 7'h30, 6);
    present(4'b0011, 7'h5B, 10);
    present(4'b0100, 7'h6D, 6);
    present(4'b1000, 7'h79, 6);
    check_eq("blank_pulses", pulse_cnt, 1);
    check_eq("blank_value", last_value, 16'h3210);
    check_eq("blank_err", last_err, 1'b0);
    present(4'h0, 7'h00, 3);

    // Long hold of digit 0 must capture once; a recapture would pre-seed the next frame
    pulse_cnt = 0;
    present(4'b0010, 7'h30, 6);
    present(4'b0100, 7'h6D, 6);
    present(4'b1000, 7'h79, 6);
    present(4'b0001, 7'h5B, 20);
    check_eq("long_state", dbg_state, ST_HELD);
    check_eq("long_pulses", pulse_cnt, 1);
    check_eq("long_value", last_value, 16'h3215);
    pulse_cnt = 0;
    present(4'b0010, 7'h4F, 6);
    present(4'b0100, 7'h47, 6);
    present(4'b1000, 7'h3D, 6);
    check_eq("long_no_early", pulse_cnt, 0);
    present(4'b0001, 7'h7E, 6);
    check_eq("long_next_pulses", pulse_cnt, 1);
    check_eq("long_next_value", last_value, 16'hDFE0);
    present(4'h0, 7'h00, 3);

    // Reset mid-frame discards partial digits
    pulse_cnt = 0;
    present(4'b0001, 7'h30, 6);
    present(4'b0010, 7'h30, 6);
    present(4'b0100, 7'h30, 6);
    rst_n = 1'b0;
    present(4'b0100, 7'h30, 3);
    check_eq("midrst_value", value, 16'h0000);
    check_eq("midrst_state", dbg_state, ST_WAIT);
    check_eq("midrst_fv", frame_valid, 1'b0);
    rst_n = 1'b1;
    present(4'b0001, 7'h7E, 6);
    present(4'b0010, 7'h7E, 6);
    present(4'b0100, 7'h7E, 6);
    present(4'b1000, 7'h47, 6);
    check_eq("postrst_pulses", pulse_cnt, 1);
    check_eq("postrst_value", last_value, 16'hF000);
    check_eq("postrst_err", last_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
